mic1_mem_sequencer: RTL and testbench
=====================================

# mic1_mem_sequencer

Memory-port sequencer for the MIC-1 core. Accepts 32-bit word read/write requests (MAR/MDR path) and byte instruction fetches (PC/MBR path), and serialises each onto the 8-bit external bus as address beats followed by data beats. Word requests take fixed priority over fetches. Pending requests are latched so that single-cycle request pulses are never lost. The block sits between the core register file and the chip pins.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: design enable; while low, all state is frozen and `bus_cmd`=00.
- `rd` in 1: word-read request pulse.
- `wr` in 1: word-write request pulse.
- `mar` in 32: word address, sampled with `rd`/`wr`.
- `mdr_wdata` in 32: write data, sampled with `wr`.
- `fetch` in 1: byte-fetch request pulse.
- `pc` in 32: byte address, sampled with `fetch`.
- `mdr_rdata` out 32: last word read; holds until the next word read completes.
- `mdr_valid` out 1: 1-cycle pulse, word read complete.
- `wr_done` out 1: 1-cycle pulse, word write complete.
- `mbr` out 8: last fetched byte; holds until the next fetch completes.
- `mbr_valid` out 1: 1-cycle pulse, fetch complete.
- `busy` out 1: FSM not in IDLE, or any request pending.
- `ovf` out 1: sticky flag, a request was dropped; cleared only by reset.
- `bus_out` out 8: address or write-data byte.
- `bus_in` in 8: read-data byte.
- `bus_cmd` out 2: beat type. 00 idle, 01 address, 10 write data, 11 read data.
- `bus_rdy` in 1: the current beat completes in a cycle where `bus_cmd`≠00, `bus_rdy`=1 and `ena`=1.

## Operation
- **Request capture** (only when `ena`=1):
  - `rd` or `wr` sets `wpend`. It latches the op, `mar`, and `mdr_wdata` (the latter only on `wr`).
  - If `rd` and `wr` are both high, the request is a write and `rd` is ignored.
  - `fetch` sets `fpend` and latches `pc`.
  - A request arriving while its own pending bit is already set, or while that port's transfer is in progress, is dropped and sets `ovf`.
  - The word port and the fetch port are independent, so one of each may be pending at the same time.
- **FSM states:** IDLE, ADDR, WDATA, RDATA, DONE.
- **IDLE:**
  - If `wpend` is set, grant the word op. The bus address is {mar[29:0],2'b00}, i.e. `mar` is a word address.
  - Otherwise, if `fpend` is set, grant the fetch. The bus address is `pc`.
  - On grant: clear that port's pending bit, load the 2-bit beat counter with 0, and go to ADDR.
  - A pending bit is never consumed in the same cycle it is set.
- **ADDR:** 4 beats, `bus_cmd`=01, `bus_out`=addr byte[beat], LSB first. After the 4th completed beat:
  - word write → WDATA;
  - word read → RDATA (4 beats);
  - fetch → RDATA (1 beat).
- **WDATA:** 4 beats, `bus_cmd`=10, `bus_out`=wdata byte[beat], LSB first. Then DONE.
- **RDATA:** `bus_cmd`=11. Each completed beat captures `bus_in` into byte[beat] of a shadow register, little-endian. Then DONE.
- **DONE:** exactly 1 cycle.
  - Word read: `mdr_rdata` is updated and `mdr_valid`=1.
  - Write: `wr_done`=1.
  - Fetch: `mbr` is updated and `mbr_valid`=1.
  - Next state is IDLE.
- **Beat counter:** advances only on a completed beat and wraps 3→0 at the phase change. Stalls (`bus_rdy`=0) hold `bus_out`, `bus_cmd`, and the counter.
- **Bus outputs:** `bus_out`=00 whenever `bus_cmd`=00.

## Timing
- **Reset values:** asserting `rst_n` low immediately (asynchronously) forces:
  - FSM=IDLE, counter=0, pending bits=0, `ovf`=0;
  - `mdr_rdata`=0, `mbr`=0;
  - all valid/done pulses=0, `busy`=0;
  - `bus_cmd`=00, `bus_out`=00.
- **Abort on reset:** a transfer in progress when reset asserts is aborted with no completion pulse.
- **Latency with `bus_rdy`=1 and `ena`=1**, request pulse in cycle 0:
  - cycle 1: grant;
  - cycles 2–5: address beats;
  - word: cycles 6–9 data beats, DONE pulse in cycle 10;
  - fetch: data beat in cycle 6, `mbr_valid` in cycle 7.
- **Back-to-back service:** after DONE, the next pending request is granted in the next IDLE cycle.
- **Stalls:** each cycle with `bus_rdy`=0 during a beat adds exactly one cycle. Each cycle with `ena`=0 adds one cycle and forces `bus_cmd`=00 for that cycle.
- **Ordering:** completion pulses are mutually exclusive, and at most one completion pulse occurs per DONE.

## Test plan
- **Reset mid-transfer:** assert `rd` with `mar`=0x1, then pull `rst_n` low during the 2nd address beat → all outputs go to reset values immediately; no `mdr_valid` afterwards.
- **Word read:** `rd` with `mar`=0x00000010, `bus_rdy`=1, `bus_in` returns 0x78, 0x56, 0x34, 0x12 → address beats 40, 00, 00, 00 in cycles 2–5; `mdr_rdata`=0x12345678 and `mdr_valid`=1 in cycle 10 only.
- **Word write with stall:** `wr` with `mar`=0x3 and `mdr_wdata`=0xDEADBEEF; hold `bus_rdy`=0 for 2 cycles during beat 1 of WDATA → bus shows 0C, 00, 00, 00 then EF, BE (held 3 cycles), AD, DE; `wr_done` in cycle 12.
- **Arbitration:** `fetch` (`pc`=0x105) and `rd` (`mar`=0x2) in the same cycle → the word read is served first (address 08, 00, 00, 00), then the fetch (address 05, 01, 00, 00, one data beat); `mdr_valid` in cycle 10, `mbr_valid` in cycle 17.
- **Overflow:** a second `fetch` while the first is pending → `ovf`=1 and stays 1; only one `mbr_valid` occurs.
- **Enable gating:** `ena`=0 for 3 cycles during ADDR → `bus_cmd`=00 in those cycles; the beat sequence resumes unchanged and completion shifts by 3 cycles.

Source files
------------

// File: rtl/mic1_mem_sequencer.sv
// Serialises MIC-1 word (MAR/MDR) and byte-fetch (PC/MBR) requests onto an
// 8-bit pin bus as 4 address beats followed by write or read data beats.
module mic1_mem_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] mar,
  input  logic [31:0] mdr_wdata,
  input  logic        fetch,
  input  logic [31:0] pc,
  output logic [31:0] mdr_rdata,
  output logic        mdr_valid,
  output logic        wr_done,
  output logic [7:0]  mbr,
  output logic        mbr_valid,
  output logic        busy,
  output logic        ovf,
  output logic [7:0]  bus_out,
  input  logic [7:0]  bus_in,
  output logic [1:0]  bus_cmd,
  input  logic        bus_rdy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_RD    = 2'd0,
    OP_WR    = 2'd1,
    OP_FETCH = 2'd2
  } op_t;

  state_t      state_r;
  op_t         op_r;
  logic [1:0]  cnt_r;
  logic        wpend_r;
  logic        wop_wr_r;
  logic [31:0] wmar_r;
  logic [31:0] wdata_r;
  logic        fpend_r;
  logic [31:0] fpc_r;
  logic [31:0] addr_r;
  logic [23:0] shadow_r;
  logic [31:0] mdr_rdata_r;
  logic [7:0]  mbr_r;
  logic        ovf_r;

  logic        word_req_s;
  logic        fetch_req_s;
  logic        word_active_s;
  logic        fetch_active_s;
  logic [1:0]  cmd_s;
  logic        beat_s;

  assign word_req_s     = ena & (rd | wr);
  assign fetch_req_s    = ena & fetch;
  assign word_active_s  = (state_r != ST_IDLE) && (op_r != OP_FETCH);
  assign fetch_active_s = (state_r != ST_IDLE) && (op_r == OP_FETCH);

  // Beat type from the current phase; ena low blanks the bus for that cycle.
  always_comb begin
    cmd_s = 2'b00;
    case (state_r)
      ST_ADDR:  cmd_s = 2'b01;
      ST_WDATA: cmd_s = 2'b10;
      ST_RDATA: cmd_s = 2'b11;
      default:  cmd_s = 2'b00;
    endcase
    if (ena) begin
      bus_cmd = cmd_s;
    end else begin
      bus_cmd = 2'b00;
    end
  end

  // Drive the addressed byte of the address or write data, LSB first.
  always_comb begin
    bus_out = 8'h00;
    if (bus_cmd == 2'b01) begin
      bus_out = addr_r[{cnt_r, 3'b000} +: 8];
    end else if (bus_cmd == 2'b10) begin
      bus_out = wdata_r[{cnt_r, 3'b000} +: 8];
    end else begin
      bus_out = 8'h00;
    end
  end

  assign beat_s    = (bus_cmd != 2'b00) & bus_rdy;
  assign mdr_valid = ena && (state_r == ST_DONE) && (op_r == OP_RD);
  assign wr_done   = ena && (state_r == ST_DONE) && (op_r == OP_WR);
  assign mbr_valid = ena && (state_r == ST_DONE) && (op_r == OP_FETCH);
  assign busy      = (state_r != ST_IDLE) | wpend_r | fpend_r;
  assign mdr_rdata = mdr_rdata_r;
  assign mbr       = mbr_r;
  assign ovf       = ovf_r;

  // Request capture, arbitration and beat sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_RD;
      cnt_r       <= 2'd0;
      wpend_r     <= 1'b0;
      wop_wr_r    <= 1'b0;
      wmar_r      <= 32'h0;
      wdata_r     <= 32'h0;
      fpend_r     <= 1'b0;
      fpc_r       <= 32'h0;
      addr_r      <= 32'h0;
      shadow_r    <= 24'h0;
      mdr_rdata_r <= 32'h0;
      mbr_r       <= 8'h00;
      ovf_r       <= 1'b0;
    end else if (ena) begin
      // A port's data registers are only rewritten when its request is accepted,
      // and acceptance is impossible while that port is pending or in flight.
      if (word_req_s) begin
        if (wpend_r || word_active_s) begin
          ovf_r <= 1'b1;
        end else begin
          wpend_r  <= 1'b1;
          wop_wr_r <= wr;
          wmar_r   <= mar;
          if (wr) begin
            wdata_r <= mdr_wdata;
          end
        end
      end
      if (fetch_req_s) begin
        if (fpend_r || fetch_active_s) begin
          ovf_r <= 1'b1;
        end else begin
          fpend_r <= 1'b1;
          fpc_r   <= pc;
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (wpend_r) begin
            wpend_r <= 1'b0;
            op_r    <= wop_wr_r ? OP_WR : OP_RD;
            addr_r  <= {wmar_r[29:0], 2'b00};
            cnt_r   <= 2'd0;
            state_r <= ST_ADDR;
          end else if (fpend_r) begin
            fpend_r <= 1'b0;
            op_r    <= OP_FETCH;
            addr_r  <= fpc_r;
            cnt_r   <= 2'd0;
            state_r <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (beat_s) begin
            cnt_r <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              state_r <= (op_r == OP_WR) ? ST_WDATA : ST_RDATA;
            end
          end
        end
        ST_WDATA: begin
          if (beat_s) begin
            cnt_r <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              state_r <= ST_DONE;
            end
          end
        end
        ST_RDATA: begin
          if (beat_s) begin
            if (op_r == OP_FETCH) begin
              mbr_r   <= bus_in;
              cnt_r   <= 2'd0;
              state_r <= ST_DONE;
            end else begin
              cnt_r <= cnt_r + 2'd1;
              case (cnt_r)
                2'd0:    shadow_r[7:0]   <= bus_in;
                2'd1:    shadow_r[15:8]  <= bus_in;
                2'd2:    shadow_r[23:16] <= bus_in;
                default: begin
                  mdr_rdata_r <= {bus_in, shadow_r};
                  state_r     <= ST_DONE;
                end
              endcase
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mic1_mem_sequencer.sv
// Directed cycle-by-cycle bench for mic1_mem_sequencer; inputs change 2 time
// units after each rising edge, outputs are checked 1 unit later.
module tb_mic1_mem_sequencer;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        rd;
  logic        wr;
  logic [31:0] mar;
  logic [31:0] mdr_wdata;
  logic        fetch;
  logic [31:0] pc;
  logic [31:0] mdr_rdata;
  logic        mdr_valid;
  logic        wr_done;
  logic [7:0]  mbr;
  logic        mbr_valid;
  logic        busy;
  logic        ovf;
  logic [7:0]  bus_out;
  logic [7:0]  bus_in;
  logic [1:0]  bus_cmd;
  logic        bus_rdy;

  int total;
  int bad;

  mic1_mem_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .rd        (rd),
    .wr        (wr),
    .mar       (mar),
    .mdr_wdata (mdr_wdata),
    .fetch     (fetch),
    .pc        (pc),
    .mdr_rdata (mdr_rdata),
    .mdr_valid (mdr_valid),
    .wr_done   (wr_done),
    .mbr       (mbr),
    .mbr_valid (mbr_valid),
    .busy      (busy),
    .ovf       (ovf),
    .bus_out   (bus_out),
    .bus_in    (bus_in),
    .bus_cmd   (bus_cmd),
    .bus_rdy   (bus_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  // Checks the bus for the current cycle, then moves to the next cycle.
  task automatic beat(input string tag, input logic [1:0] cmd, input logic [7:0] data);
    #1;
    chk({tag, "_cmd"}, 32'(bus_cmd), 32'(cmd));
    chk({tag, "_out"}, 32'(bus_out), 32'(data));
    next();
  endtask

  task automatic pulses(input string tag, input logic mv, input logic wd, input logic bv);
    #1;
    chk({tag, "_mdr_valid"}, 32'(mdr_valid), 32'(mv));
    chk({tag, "_wr_done"}, 32'(wr_done), 32'(wd));
    chk({tag, "_mbr_valid"}, 32'(mbr_valid), 32'(bv));
  endtask

  initial begin
    logic [7:0] rbytes [4];
    total = 0;
    bad = 0;
    rst_n = 1'b1;
    ena = 1'b1;
    rd = 1'b0;
    wr = 1'b0;
    fetch = 1'b0;
    mar = 32'h0;
    mdr_wdata = 32'h0;
    pc = 32'h0;
    bus_in = 8'h00;
    bus_rdy = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cmd", 32'(bus_cmd), 32'h0);
    chk("rst_out", 32'(bus_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_mdr", mdr_rdata, 32'h0);
    chk("rst_mbr", 32'(mbr), 32'h0);
    pulses("rst", 1'b0, 1'b0, 1'b0);
    next();
    next();
    rst_n = 1'b1;
    next();

    // Word read, mar=0x10 -> bus address 0x40.
    rd = 1'b1; mar = 32'h0000_0010;
    #1 chk("rd_c0_busy", 32'(busy), 32'h0);
    next();
    rd = 1'b0;
    #1 chk("rd_c1_busy", 32'(busy), 32'h1);
    beat("rd_c1", 2'b00, 8'h00);
    beat("rd_a0", 2'b01, 8'h40);
    beat("rd_a1", 2'b01, 8'h00);
    beat("rd_a2", 2'b01, 8'h00);
    beat("rd_a3", 2'b01, 8'h00);
    rbytes[0] = 8'h78; rbytes[1] = 8'h56; rbytes[2] = 8'h34; rbytes[3] = 8'h12;
    for (int i = 0; i < 4; i++) begin
      bus_in = rbytes[i];
      if (i == 3) pulses("rd_c9", 1'b0, 1'b0, 1'b0);
      beat("rd_d", 2'b11, 8'h00);
    end
    pulses("rd_c10", 1'b1, 1'b0, 1'b0);
    chk("rd_c10_data", mdr_rdata, 32'h1234_5678);
    next();
    pulses("rd_c11", 1'b0, 1'b0, 1'b0);
    chk("rd_c11_busy", 32'(busy), 32'h0);
    chk("rd_c11_hold", mdr_rdata, 32'h1234_5678);
    next();

    // Word write with a 2-cycle stall on WDATA beat 1.
    wr = 1'b1; mar = 32'h0000_0003; mdr_wdata = 32'hDEAD_BEEF;
    next();
    wr = 1'b0; mdr_wdata = 32'h0;
    beat("wr_c1", 2'b00, 8'h00);
    beat("wr_a0", 2'b01, 8'h0C);
    beat("wr_a1", 2'b01, 8'h00);
    beat("wr_a2", 2'b01, 8'h00);
    beat("wr_a3", 2'b01, 8'h00);
    beat("wr_d0", 2'b10, 8'hEF);
    bus_rdy = 1'b0;
    beat("wr_d1s1", 2'b10, 8'hBE);
    beat("wr_d1s2", 2'b10, 8'hBE);
    bus_rdy = 1'b1;
    beat("wr_d1", 2'b10, 8'hBE);
    beat("wr_d2", 2'b10, 8'hAD);
    pulses("wr_c11", 1'b0, 1'b0, 1'b0);
    beat("wr_d3", 2'b10, 8'hDE);
    pulses("wr_c12", 1'b0, 1'b1, 1'b0);
    chk("wr_c12_mdr_hold", mdr_rdata, 32'h1234_5678);
    beat("wr_c12", 2'b00, 8'h00);
    pulses("wr_c13", 1'b0, 1'b0, 1'b0);
    next();

    // Fetch with ena low for 3 cycles during ADDR.
    fetch = 1'b1; pc = 32'h4433_2211;
    next();
    fetch = 1'b0;
    beat("en_c1", 2'b00, 8'h00);
    beat("en_a0", 2'b01, 8'h11);
    ena = 1'b0;
    beat("en_off1", 2'b00, 8'h00);
    beat("en_off2", 2'b00, 8'h00);
    beat("en_off3", 2'b00, 8'h00);
    ena = 1'b1;
    beat("en_a1", 2'b01, 8'h22);
    beat("en_a2", 2'b01, 8'h33);
    beat("en_a3", 2'b01, 8'h44);
    bus_in = 8'h5A;
    beat("en_d0", 2'b11, 8'h00);
    pulses("en_c10", 1'b0, 1'b0, 1'b1);
    chk("en_c10_mbr", 32'(mbr), 32'h5A);
    next();
    pulses("en_c11", 1'b0, 1'b0, 1'b0);
    next();

    // Arbitration: rd and fetch together; second fetch while pending -> ovf.
    rd = 1'b1; mar = 32'h0000_0002; fetch = 1'b1; pc = 32'h0000_0105;
    next();
    rd = 1'b0; fetch = 1'b0;
    beat("arb_c1", 2'b00, 8'h00);
    beat("arb_a0", 2'b01, 8'h08);
    fetch = 1'b1; pc = 32'h0000_0200;
    #1 chk("arb_c3_ovf", 32'(ovf), 32'h0);
    beat("arb_a1", 2'b01, 8'h00);
    fetch = 1'b0;
    #1 chk("arb_c4_ovf", 32'(ovf), 32'h1);
    beat("arb_a2", 2'b01, 8'h00);
    beat("arb_a3", 2'b01, 8'h00);
    rbytes[0] = 8'hA1; rbytes[1] = 8'hB2; rbytes[2] = 8'hC3; rbytes[3] = 8'hD4;
    for (int i = 0; i < 4; i++) begin
      bus_in = rbytes[i];
      beat("arb_wd", 2'b11, 8'h00);
    end
    pulses("arb_c10", 1'b1, 1'b0, 1'b0);
    chk("arb_c10_data", mdr_rdata, 32'hD4C3_B2A1);
    beat("arb_c10", 2'b00, 8'h00);
    #1 chk("arb_c11_busy", 32'(busy), 32'h1);
    beat("arb_c11", 2'b00, 8'h00);
    beat("arb_f0", 2'b01, 8'h05);
    beat("arb_f1", 2'b01, 8'h01);
    beat("arb_f2", 2'b01, 8'h00);
    beat("arb_f3", 2'b01, 8'h00);
    bus_in = 8'h9C;
    pulses("arb_c16", 1'b0, 1'b0, 1'b0);
    beat("arb_fd", 2'b11, 8'h00);
    pulses("arb_c17", 1'b0, 1'b0, 1'b1);
    chk("arb_c17_mbr", 32'(mbr), 32'h9C);
    next();
    for (int i = 0; i < 8; i++) begin
      pulses("ovf_after", 1'b0, 1'b0, 1'b0);
      chk("ovf_after_bus", 32'(bus_cmd), 32'h0);
      next();
    end
    chk("ovf_sticky", 32'(ovf), 32'h1);
    chk("ovf_busy", 32'(busy), 32'h0);

    // Reset during the 2nd address beat aborts the read.
    rd = 1'b1; mar = 32'h0000_0001;
    next();
    rd = 1'b0;
    beat("ab_c1", 2'b00, 8'h00);
    beat("ab_a0", 2'b01, 8'h04);
    #1 chk("ab_a1_cmd", 32'(bus_cmd), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ab_rst_cmd", 32'(bus_cmd), 32'h0);
    chk("ab_rst_out", 32'(bus_out), 32'h0);
    chk("ab_rst_busy", 32'(busy), 32'h0);
    chk("ab_rst_ovf", 32'(ovf), 32'h0);
    chk("ab_rst_mdr", mdr_rdata, 32'h0);
    chk("ab_rst_mbr", 32'(mbr), 32'h0);
    next();
    next();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      pulses("ab_after", 1'b0, 1'b0, 1'b0);
      chk("ab_after_cmd", 32'(bus_cmd), 32'h0);
      next();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
